// File: rtl/decode_1r20i_pipe.sv
// Registered multi-lane decode/execute stage for the LoongArch 1R20I group
// (LU12I.W, LU32I.D, PCADDI, PCALAU12I, PCADDU12I, PCADDU18I).
module decode_1r20i_pipe #(
  parameter int LANES = 2,
  parameter int XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES-1:0]      in_lane_mask,
  input  logic [LANES*32-1:0]   in_instr,
  input  logic [LANES*XLEN-1:0] in_pc,
  input  logic [LANES*XLEN-1:0] in_rd_old,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      out_lane_mask,
  output logic [LANES*3-1:0]    out_op,
  output logic [LANES*5-1:0]    out_rd,
  output logic [LANES*XLEN-1:0] out_result,
  output logic [LANES-1:0]      out_illegal,
  output logic [31:0]           decoded_count
);

  localparam logic [2:0] OP_INVALID   = 3'd0;
  localparam logic [2:0] OP_LU12I     = 3'd1;
  localparam logic [2:0] OP_LU32I     = 3'd2;
  localparam logic [2:0] OP_PCADDI    = 3'd3;
  localparam logic [2:0] OP_PCALAU12I = 3'd4;
  localparam logic [2:0] OP_PCADDU12I = 3'd5;
  localparam logic [2:0] OP_PCADDU18I = 3'd6;

  typedef struct packed {
    logic [2:0]      op;
    logic            illegal;
    logic [XLEN-1:0] result;
  } lane_dec_t;

  // Immediates are sign-extended from their shifted width straight to XLEN.
  function automatic lane_dec_t decode_lane(
    input logic [31:0]     instr,
    input logic [XLEN-1:0] pc,
    input logic [XLEN-1:0] rd_old,
    input logic            en
  );
    lane_dec_t d;
    logic [19:0] si20;
    logic [XLEN-1:0] imm12;
    si20  = instr[24:5];
    imm12 = XLEN'($signed({si20, 12'h000}));
    d.op      = OP_INVALID;
    d.illegal = 1'b0;
    d.result  = '0;
    if (en) begin
      case (instr[31:25])
        7'b0001010: begin
          d.op     = OP_LU12I;
          d.result = imm12;
        end
        7'b0001011: begin
          if (XLEN == 64) begin
            d.op     = OP_LU32I;
            d.result = XLEN'({{12{si20[19]}}, si20, rd_old[31:0]});
          end else begin
            d.illegal = 1'b1;
          end
        end
        7'b0001100: begin
          d.op     = OP_PCADDI;
          d.result = pc + XLEN'($signed({si20, 2'b00}));
        end
        7'b0001101: begin
          d.op     = OP_PCALAU12I;
          d.result = (pc + imm12) & ~XLEN'(12'hFFF);
        end
        7'b0001110: begin
          d.op     = OP_PCADDU12I;
          d.result = pc + imm12;
        end
        7'b0001111: begin
          if (XLEN == 64) begin
            d.op     = OP_PCADDU18I;
            d.result = pc + XLEN'($signed({si20, 18'h00000}));
          end else begin
            d.illegal = 1'b1;
          end
        end
        default: begin
          d.op = OP_INVALID;
        end
      endcase
    end else begin
      d.op = OP_INVALID;
    end
    return d;
  endfunction

  logic                  accept_s;
  lane_dec_t             dec_s;
  logic [LANES*3-1:0]    op_nxt_s;
  logic [LANES*5-1:0]    rd_nxt_s;
  logic [LANES*XLEN-1:0] result_nxt_s;
  logic [LANES-1:0]      illegal_nxt_s;
  logic [3:0]            hits_s;
  logic [32:0]           sum_s;
  logic [31:0]           count_nxt_s;

  assign in_ready = !out_valid || out_ready;
  assign accept_s = in_valid && in_ready && !flush;

  // Per-lane decode of the offered bundle plus the saturated count update.
  always_comb begin
    dec_s         = '0;
    op_nxt_s      = '0;
    rd_nxt_s      = '0;
    result_nxt_s  = '0;
    illegal_nxt_s = '0;
    hits_s        = 4'd0;
    for (int i = 0; i < LANES; i++) begin
      dec_s = decode_lane(in_instr[32*i +: 32], in_pc[XLEN*i +: XLEN],
                          in_rd_old[XLEN*i +: XLEN], in_lane_mask[i]);
      op_nxt_s[3*i +: 3]          = dec_s.op;
      rd_nxt_s[5*i +: 5]          = in_instr[32*i +: 5];
      result_nxt_s[XLEN*i +: XLEN] = dec_s.result;
      illegal_nxt_s[i]            = dec_s.illegal;
      hits_s = hits_s + {3'b000, (dec_s.op != OP_INVALID)};
    end
    sum_s = {1'b0, decoded_count} + {29'd0, hits_s};
    if (sum_s[32]) begin
      count_nxt_s = 32'hFFFF_FFFF;
    end else begin
      count_nxt_s = sum_s[31:0];
    end
  end

  // Output bundle register: flush beats accept, accept beats handoff.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_lane_mask <= '0;
      out_op        <= '0;
      out_rd        <= '0;
      out_result    <= '0;
      out_illegal   <= '0;
      decoded_count <= 32'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept_s) begin
      out_valid     <= 1'b1;
      out_lane_mask <= in_lane_mask;
      out_op        <= op_nxt_s;
      out_rd        <= rd_nxt_s;
      out_result    <= result_nxt_s;
      out_illegal   <= illegal_nxt_s;
      decoded_count <= count_nxt_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_1r20i_pipe.sv
// Directed bench: a 32-bit and a 64-bit instance share control and instructions.
module tb_decode_1r20i_pipe;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, out_ready;
  logic [1:0]   lane_mask;
  logic [63:0]  instr;
  logic [63:0]  pc32, rd32;
  logic [127:0] pc64, rd64;

  logic         in_ready32, out_valid32, in_ready64, out_valid64;
  logic [1:0]   lane_mask32, lane_mask64, illegal32, illegal64;
  logic [5:0]   op32, op64;
  logic [9:0]   rd_out32, rd_out64;
  logic [63:0]  result32;
  logic [127:0] result64;
  logic [31:0]  count32, count64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_1r20i_pipe #(.LANES(2), .XLEN(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_lane_mask(lane_mask), .in_instr(instr), .in_pc(pc32), .in_rd_old(rd32),
    .out_valid(out_valid32), .out_ready(out_ready), .out_lane_mask(lane_mask32),
    .out_op(op32), .out_rd(rd_out32), .out_result(result32), .out_illegal(illegal32),
    .decoded_count(count32)
  );

  decode_1r20i_pipe #(.LANES(2), .XLEN(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_lane_mask(lane_mask), .in_instr(instr), .in_pc(pc64), .in_rd_old(rd64),
    .out_valid(out_valid64), .out_ready(out_ready), .out_lane_mask(lane_mask64),
    .out_op(op64), .out_rd(rd_out64), .out_result(result64), .out_illegal(illegal64),
    .decoded_count(count64)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    lane_mask = 2'b00; instr = 64'd0; pc32 = 64'd0; rd32 = 64'd0;
    pc64 = 128'd0; rd64 = 128'd0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("reset_out_valid", out_valid32, 1'b0);
    check("reset_in_ready", in_ready32, 1'b1);
    check("reset_count", count32, 32'd0);
    check("reset_result", result32, 64'd0);
    check("reset_op", op32, 6'd0);

    // Bundle A: LU12I + PCADDU12I wrapping
    lane_mask = 2'b11;
    instr = {32'h1DFF_FFE4, 32'h1400_002C};
    pc32 = {32'h0000_0100, 32'h0000_0000};
    pc64 = {64'h100, 64'h0};
    in_valid = 1'b1;
    #1;
    check("pre_accept_valid", out_valid32, 1'b0);
    tick();
    check("a_valid", out_valid32, 1'b1);
    check("a_op", op32, {3'd5, 3'd1});
    check("a_rd", rd_out32, {5'd4, 5'd12});
    check("a_result", result32, {32'hFFFF_F100, 32'h0000_1000});
    check("a_illegal", illegal32, 2'b00);
    check("a_count", count32, 32'd2);

    // Backpressure: bundle B offered while A is stalled
    out_ready = 1'b0;
    instr = {32'h1400_002C, 32'h1800_0062};
    pc32 = {32'h0, 32'h0000_1000};
    pc64 = {64'h0, 64'h1000};
    #1;
    check("bp_in_ready", in_ready32, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_valid", out_valid32, 1'b1);
      check("bp_result_held", result32, {32'hFFFF_F100, 32'h0000_1000});
      check("bp_count_held", count32, 32'd2);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready32, 1'b1);
    tick();
    check("b_valid", out_valid32, 1'b1);
    check("b_op", op32, {3'd1, 3'd3});
    check("b_result", result32, {32'h0000_1000, 32'h0000_100C});
    check("b_count", count32, 32'd4);
    check("b64_pcaddi", result64[63:0], 64'h100C);
    check("b64_op", op64, {3'd1, 3'd3});
    in_valid = 1'b0;
    tick();
    check("b_drained", out_valid32, 1'b0);
    check("b_no_dup", count32, 32'd4);

    // Bundle C: LU32I + PCALAU12I (legal on 64, lane0 illegal on 32)
    in_valid = 1'b1;
    instr = {32'h1A00_0041, 32'h1700_0005};
    rd64 = {64'h0, 64'h0000_0000_1234_5678};
    rd32 = {32'h0, 32'h1234_5678};
    pc64 = {64'h1_0000_0FFC, 64'h0};
    pc32 = {32'h0000_0FFC, 32'h0};
    tick();
    check("c64_op", op64, {3'd4, 3'd2});
    check("c64_rd", rd_out64, {5'd1, 5'd5});
    check("c64_result", result64, {64'h1_0000_2000, 64'hFFF8_0000_1234_5678});
    check("c64_illegal", illegal64, 2'b00);
    check("c64_count", count64, 32'd6);
    check("c32_op", op32, {3'd4, 3'd0});
    check("c32_illegal", illegal32, 2'b01);
    check("c32_result", result32, {32'h0000_2000, 32'h0});
    check("c32_count", count32, 32'd5);

    // Bundle D: only the illegal lane enabled on 32
    lane_mask = 2'b01;
    instr = {32'h1400_002C, 32'h1700_0005};
    tick();
    check("d_op", op32, 6'd0);
    check("d_illegal", illegal32, 2'b01);
    check("d_rd_masked", rd_out32, {5'd12, 5'd5});
    check("d_count", count32, 32'd5);

    // Bundle F: lane1 masked off
    instr = {32'h1DFF_FFE4, 32'h1400_002C};
    pc32 = {32'h0000_0100, 32'h0};
    tick();
    check("f_op", op32, {3'd0, 3'd1});
    check("f_result", result32, {32'h0, 32'h0000_1000});
    check("f_mask", lane_mask32, 2'b01);
    check("f_count", count32, 32'd6);

    // Bundle G: non-group opcode in lane0
    lane_mask = 2'b11;
    instr = {32'h1400_002C, 32'h0280_0000};
    tick();
    check("g_op", op32, {3'd1, 3'd0});
    check("g_illegal", illegal32, 2'b00);
    check("g_result", result32, {32'h0000_1000, 32'h0});
    check("g_count", count32, 32'd7);

    // Bundle E held, then flush with a new offer
    instr = {32'h1400_002C, 32'h1400_002C};
    tick();
    check("e_count", count32, 32'd9);
    out_ready = 1'b0;
    flush = 1'b1;
    instr = {32'h1800_0062, 32'h1800_0062};
    tick();
    check("flush_valid", out_valid32, 1'b0);
    check("flush_count", count32, 32'd9);
    flush = 1'b0;
    tick();
    check("post_flush_accept", out_valid32, 1'b1);
    check("post_flush_count", count32, 32'd11);

    // Reset mid-stall
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_valid", out_valid32, 1'b0);
    check("rst_in_ready", in_ready32, 1'b1);
    check("rst_op", op32, 6'd0);
    check("rst_rd", rd_out32, 10'd0);
    check("rst_result", result32, 64'd0);
    check("rst_illegal", illegal32, 2'b00);
    check("rst_mask", lane_mask32, 2'b00);
    check("rst_count", count32, 32'd0);
    check("rst_count64", count64, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
